// File: rtl/mem_copy_engine.sv
// Block-copy engine: moves len words from src to dst through a single-port
// memory, one read and one write per word, then pulses done.
module mem_copy_engine #(
  parameter int ADDR_LEN  = 8,
  parameter int WORD_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_LEN-1:0]  src_addr,
  input  logic [ADDR_LEN-1:0]  dst_addr,
  input  logic [ADDR_LEN-1:0]  len,
  output logic                 busy,
  output logic                 done,
  output logic [ADDR_LEN-1:0]  words_done,
  output logic [ADDR_LEN-1:0]  mem_addr,
  output logic                 mem_r_en,
  output logic                 mem_w_en,
  output logic [WORD_SIZE-1:0] mem_data_in,
  input  logic [WORD_SIZE-1:0] mem_data_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_LEN-1:0]  src_q, src_d;
  logic [ADDR_LEN-1:0]  dst_q, dst_d;
  logic [ADDR_LEN-1:0]  rem_q, rem_d;
  logic [ADDR_LEN-1:0]  cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] buf_q, buf_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d = '0;
          if (len != '0) begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            rem_d   = len;
            state_d = READ;
          end else begin
            state_d = DONE;
          end
        end
      end
      READ: begin
        buf_d   = mem_data_out;
        state_d = WRITE;
      end
      WRITE: begin
        src_d   = src_q + 1'b1;
        dst_d   = dst_q + 1'b1;
        rem_d   = rem_q - 1'b1;
        cnt_d   = cnt_q + 1'b1;
        state_d = (rem_q == ADDR_LEN'(1)) ? DONE : READ;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode from registered state only; no path from start.
  always_comb begin
    mem_r_en = (state_q == READ);
    mem_w_en = (state_q == WRITE);
    busy     = mem_r_en | mem_w_en;
    done     = (state_q == DONE);
    mem_addr = '0;
    if (mem_r_en) mem_addr = src_q;
    if (mem_w_en) mem_addr = dst_q;
  end

  assign mem_data_in = buf_q;
  assign words_done  = cnt_q;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine: behavioural memory plus a scoreboard of
// expected reads and writes, checked as the engine issues them.
module tb_mem_copy_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] src_addr, dst_addr, len;
  logic       busy, done, mem_r_en, mem_w_en;
  logic [7:0] words_done, mem_addr, mem_data_in, mem_data_out;

  logic [7:0] mem  [256];
  logic [7:0] rmem [256];
  logic       ld_en;
  logic [7:0] ld_a, ld_d;

  logic [7:0]  rq [$];
  logic [15:0] wq [$];

  int checks   = 0;
  int failures = 0;
  int wcnt     = 0;
  int dcnt     = 0;

  always #5 clk = ~clk;

  mem_copy_engine #(.ADDR_LEN(8), .WORD_SIZE(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .src_addr     (src_addr),
    .dst_addr     (dst_addr),
    .len          (len),
    .busy         (busy),
    .done         (done),
    .words_done   (words_done),
    .mem_addr     (mem_addr),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  assign mem_data_out = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_w_en) mem[mem_addr] <= mem_data_in;
    else if (ld_en) mem[ld_a] <= ld_d;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      logic [15:0] w;
      logic [7:0]  a;
      chk("excl", 32'(mem_r_en && mem_w_en), 0);
      chk("busy_dec", 32'(busy), 32'(mem_r_en | mem_w_en));
      if (mem_r_en) begin
        chk("rd_pending", 32'(rq.size() != 0), 1);
        if (rq.size() != 0) begin
          a = rq.pop_front();
          chk("rd_addr", 32'(mem_addr), 32'(a));
        end
      end
      if (mem_w_en) begin
        wcnt++;
        chk("wr_pending", 32'(wq.size() != 0), 1);
        if (wq.size() != 0) begin
          w = wq.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(w[15:8]));
          chk("wr_data", 32'(mem_data_in), 32'(w[7:0]));
        end
      end
      if (done) dcnt++;
    end
  end

  task automatic zero_outs(input string tag);
    chk({tag, "_ctl"}, {busy, done, mem_r_en, mem_w_en}, 0);
    chk({tag, "_addr"}, 32'(mem_addr), 0);
    chk({tag, "_wd"}, 32'(mem_data_in), 0);
    chk({tag, "_words"}, 32'(words_done), 0);
  endtask

  // mode 0: plain job, 1: second start during WRITE, 2: reset in 2nd WRITE
  task automatic run_job(input logic [7:0] s, input logic [7:0] d,
                         input logic [7:0] l, input int mode);
    int n, nb, w0, d0;
    logic [7:0] sa, da;
    logic [7:0] old [5];
    w0 = wcnt;
    d0 = dcnt;
    nb = 0;
    for (int i = 0; i < 5; i++) old[i] = rmem[8'(d + 8'(i))];
    for (int i = 0; i < int'(l); i++) begin
      sa = s + 8'(i);
      da = d + 8'(i);
      rq.push_back(sa);
      wq.push_back({da, rmem[sa]});
      rmem[da] = rmem[sa];
    end
    @(posedge clk); #1;
    start = 1'b1; src_addr = s; dst_addr = d; len = l;
    @(posedge clk); #1;
    start = 1'b0;
    src_addr = 8'($urandom); dst_addr = 8'($urandom); len = 8'($urandom);
    n = 1;
    while (!done && n <= 2 * int'(l) + 6) begin
      if (busy) nb++;
      if (mode == 1 && n == 2) begin
        start = 1'b1; len = 8'd4;
      end else if (mode == 1 && n == 3) begin
        start = 1'b0;
      end
      if (mode == 2 && n == 4) begin
        chk("abort_in_wr", 32'(mem_w_en), 1);
        #2 rst = 1'b1;
        #1 zero_outs("abort");
        rq.delete();
        wq.delete();
        @(posedge clk); #1;
        zero_outs("abort_hold");
        rst = 1'b0;
        chk("abort_dst0", 32'(mem[d]), 32'(rmem[d]));
        chk("abort_dst1", 32'(mem[8'(d + 8'd1)]), 32'(old[1]));
        chk("abort_dst2", 32'(mem[8'(d + 8'd2)]), 32'(old[2]));
        for (int i = 1; i < 5; i++) rmem[8'(d + 8'(i))] = old[i];
        chk("abort_wr_cnt", 32'(wcnt - w0), 1);
        return;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("done_lat", 32'(n), 32'(2 * int'(l) + 1));
    chk("done", 32'(done), 1);
    chk("busy_at_done", 32'(busy), 0);
    chk("busy_cycles", 32'(nb), 32'(2 * int'(l)));
    chk("words_done", 32'(words_done), 32'(l));
    repeat (6) @(posedge clk);
    #1;
    chk("wr_cnt", 32'(wcnt - w0), 32'(l));
    chk("done_cnt", 32'(dcnt - d0), 1);
    chk("words_hold", 32'(words_done), 32'(l));
    chk("rq_left", 32'(rq.size()), 0);
    chk("wq_left", 32'(wq.size()), 0);
  endtask

  initial begin
    int bad;
    logic [7:0] pat [4];
    rst = 1'b1; start = 1'b0; ld_en = 1'b0; ld_a = '0; ld_d = '0;
    src_addr = '0; dst_addr = '0; len = '0;
    #3 zero_outs("reset");
    pat = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    for (int i = 0; i < 256; i++) begin
      rmem[i] = 8'($urandom);
      if (i >= 8'h10 && i <= 8'h13) rmem[i] = pat[i - 8'h10];
    end
    ld_en = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      ld_a = 8'(i);
      ld_d = rmem[i];
    end
    @(negedge clk);
    ld_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_job(8'h10, 8'h80, 8'd4, 0);
    chk("basic_80", 32'(mem[8'h80]), 32'hA1);
    chk("basic_83", 32'(mem[8'h83]), 32'hD4);
    run_job(8'h20, 8'h90, 8'd0, 0);
    run_job(8'hFE, 8'h02, 8'd3, 0);
    run_job(8'h30, 8'hA0, 8'd2, 1);
    run_job(8'h40, 8'hB0, 8'd5, 2);
    repeat (2) @(posedge clk);
    #1 zero_outs("post_abort");
    run_job(8'h40, 8'hB0, 8'd5, 0);
    run_job(8'h50, 8'h52, 8'd4, 0);
    run_job(8'hF0, 8'h10, 8'd20, 0);
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== rmem[i]) bad++;
    chk("mem_image", 32'(bad), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
